// File: rtl/alu_64bit_if.sv
// Operand/result bundle for alu_64bit.
// Under ALU64_FLAGS_EN the bundle also carries the registered zero/ovf flags.
interface alu_64bit_if;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [1:0]  op;
  logic        in_valid;
  logic [63:0] s;
  logic        cout;
  logic        out_valid;
`ifdef ALU64_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif

  modport master (
    output a, b, cin, op, in_valid,
    input  s, cout, out_valid
`ifdef ALU64_FLAGS_EN
    , input zero, ovf
`endif
  );

  modport slave (
    input  a, b, cin, op, in_valid,
    output s, cout, out_valid
`ifdef ALU64_FLAGS_EN
    , output zero, ovf
`endif
  );
endinterface

// File: rtl/alu_64bit.sv
// Registered 64-bit NOR/XOR/ADD/SUB execute-stage ALU, latency 1.
// Optional macro ALU64_FLAGS_EN adds registered zero/ovf flags.
module alu_64bit (
  input  logic          clk,
  input  logic          rst_n,
  alu_64bit_if.slave    bus
);

  logic        sub;
  logic [63:0] bx;
  logic        ci;
  logic [64:0] sum;
  logic [63:0] res;
  logic        c;
`ifdef ALU64_FLAGS_EN
  logic        v;
`endif

  // One shared adder; subtract is a + ~b + ~cin.
  always_comb begin
    sub = (bus.op == 2'b11);
    bx  = sub ? ~bus.b : bus.b;
    ci  = sub ? ~bus.cin : bus.cin;
    sum = {1'b0, bus.a} + {1'b0, bx} + {64'd0, ci};
    res = '0;
    c   = 1'b0;
`ifdef ALU64_FLAGS_EN
    v   = 1'b0;
`endif
    unique case (1'b1)
      bus.op == 2'b00: res = ~(bus.a | bus.b);
      bus.op == 2'b01: res = bus.a ^ bus.b;
      bus.op[1]: begin
        res = sum[63:0];
        c   = sum[64];
`ifdef ALU64_FLAGS_EN
        v   = (bus.a[63] == bx[63]) &&
              (sum[63] != bus.a[63]);
`endif
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s         <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef ALU64_FLAGS_EN
      bus.zero      <= 1'b0;
      bus.ovf       <= 1'b0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s    <= res;
        bus.cout <= c;
`ifdef ALU64_FLAGS_EN
        bus.zero <= (res == 64'd0);
        bus.ovf  <= v;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed vectors plus random ops
// checked every cycle against an arithmetic reference model.
module tb_alu_64bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_64bit_if bus ();

  alu_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on widened values.
  function automatic void ref_op(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic [1:0]  op,
    output logic [63:0] s,
    output logic        c,
    output logic        v
  );
    logic [64:0] wide;
    logic signed [65:0] sg;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'd0: s = ~(a | b);
      2'd1: s = a ^ b;
      2'd2: begin
        wide = 65'(a) + 65'(b) + 65'(cin);
        s = wide[63:0];
        c = wide[64];
        sg = 66'($signed(a)) + 66'($signed(b)) + 66'(cin);
        v = (sg > 66'sd9223372036854775807) ||
            (sg < -66'sd9223372036854775808);
      end
      default: begin
        s = a - b - 64'(cin);
        c = (65'(a) >= 65'(b) + 65'(cin));
        sg = 66'($signed(a)) - 66'($signed(b)) - 66'(cin);
        v = (sg > 66'sd9223372036854775807) ||
            (sg < -66'sd9223372036854775808);
      end
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state
  logic [63:0] m_s;
  logic        m_c;
  logic        m_vld;
  logic        m_z;
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] ts;
    logic        tc;
    logic        tv;
    if (!rst_n) begin
      m_s <= '0; m_c <= 1'b0; m_vld <= 1'b0;
      m_z <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_vld <= bus.in_valid;
      if (bus.in_valid) begin
        ref_op(bus.a, bus.b, bus.cin, bus.op, ts, tc, tv);
        m_s <= ts; m_c <= tc;
        m_z <= (ts == 0); m_ovf <= tv;
      end
    end
  end

  logic cmp_en;
  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      chk("cyc_s", bus.s, m_s);
      chk("cyc_cout", 64'(bus.cout), 64'(m_c));
      chk("cyc_valid", 64'(bus.out_valid), 64'(m_vld));
`ifdef ALU64_FLAGS_EN
      chk("cyc_zero", 64'(bus.zero), 64'(m_z));
      chk("cyc_ovf", 64'(bus.ovf), 64'(m_ovf));
`endif
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic [1:0] op,
                       input logic vld);
    bus.a = a; bus.b = b; bus.cin = cin;
    bus.op = op; bus.in_valid = vld;
  endtask

  // Apply one op, step one edge, check DUT against literal values.
  task automatic lit(input string name, input logic [63:0] a,
                     input logic [63:0] b, input logic cin,
                     input logic [1:0] op, input logic [63:0] es,
                     input logic ec);
    logic [63:0] ts;
    logic        tc;
    logic        tv;
    ref_op(a, b, cin, op, ts, tc, tv);
    chk({name, "_model_s"}, ts, es);
    chk({name, "_model_c"}, 64'(tc), 64'(ec));
    drive(a, b, cin, op, 1'b1);
    @(posedge clk); #1;
    chk({name, "_s"}, bus.s, es);
    chk({name, "_c"}, 64'(bus.cout), 64'(ec));
    chk({name, "_v"}, 64'(bus.out_valid), 64'd1);
  endtask

  localparam logic [63:0] VA = 64'h7DFBFFBF7FFFBF7D;
  localparam logic [63:0] VB = 64'h4303CFEF2061F1C3;

  initial begin
    logic [63:0] hold_s;
    logic        hold_c;
    n_checks = 0; n_fail = 0; cmp_en = 1'b0;
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    chk("rst_s", bus.s, 64'd0);
    chk("rst_c", 64'(bus.cout), 64'd0);
    chk("rst_v", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    lit("carry0", 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 2'd2,
        64'hFFFFFFFFFFFFFFFF, 1'b0);
    lit("carry1", 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 2'd2,
        64'd0, 1'b1);
    lit("mix_add", VA, VB, 1'b0, 2'd2, 64'hC0FFCFAEA061B140, 1'b0);
    lit("mix_sub", VA, VB, 1'b0, 2'd3, 64'h3AF82FD05F9DCDBA, 1'b1);
    lit("mix_nor", VA, VB, 1'b1, 2'd0, 64'h8004000080000000, 1'b0);
    lit("mix_xor", VA, VB, 1'b1, 2'd1, 64'h3EF830505F9E4EBE, 1'b0);
    lit("borrow", 64'd0, 64'd1, 1'b0, 2'd3,
        64'hFFFFFFFFFFFFFFFF, 1'b0);
    lit("bwin", 64'd5, 64'd2, 1'b1, 2'd3, 64'd2, 1'b1);
    lit("addcin", 64'd5, 64'd2, 1'b1, 2'd2, 64'd8, 1'b0);

    // Hold while idle
    hold_s = 64'd8; hold_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
            2'($urandom), 1'b0);
      @(posedge clk); #1;
      chk("idle_s", bus.s, hold_s);
      chk("idle_c", 64'(bus.cout), 64'(hold_c));
      chk("idle_v", 64'(bus.out_valid), 64'd0);
    end
    lit("resume", 64'd100, 64'd58, 1'b0, 2'd3, 64'd42, 1'b1);

    // Async reset mid-cycle with a live op
    drive(64'd1, 64'd1, 1'b0, 2'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", bus.s, 64'd0);
    chk("arst_c", 64'(bus.cout), 64'd0);
    chk("arst_v", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("arst_hold_v", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 400; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = 64'hFFFFFFFFFFFFFFFF;
        1: rb = ra;
        2: ra = 64'h8000000000000000;
        3: rb = 64'h7FFFFFFFFFFFFFFF;
        default: ;
      endcase
      drive(ra, rb, 1'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 8));
      @(posedge clk); #1;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
